// File: rtl/hybrid_noc_router_lookup_sr_buf_if.sv
// Flit link bundle for the source-routed lookup stage.
// LANES = 1 for the upstream link; LANES = PORTS gives per-port valid/ready on the arbiter side.
interface hybrid_noc_router_lookup_sr_buf_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int LANES      = 1
);
  logic [FLIT_WIDTH-1:0] flit;
  logic [LANES-1:0]      valid;
  logic                  last;
  logic [LANES-1:0]      ready;

  modport master (output flit, output valid, output last, input  ready);
  modport slave  (input  flit, input  valid, input  last, output ready);
endinterface

// File: rtl/hybrid_noc_router_lookup_sr_buf.sv
// Source-routed input lookup stage: consumes the per-hop route, back-traces the header, drops bad routes, buffers in a FIFO.
// Optional macro HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN adds a saturating drop_count output.
module hybrid_noc_router_lookup_sr_buf #(
  parameter int FLIT_WIDTH     = 32,
  parameter int PORTS          = 5,
  parameter int INPUT_ID       = 0,
  parameter int HEADER_WIDTH   = 8,
  parameter int DEPTH          = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  hybrid_noc_router_lookup_sr_buf_if.slave  in_link,
  hybrid_noc_router_lookup_sr_buf_if.master out_link
`ifdef HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

  localparam int ROUTE_WIDTH   = $clog2(PORTS + 1);
  localparam int ROUTING_WIDTH = FLIT_WIDTH - HEADER_WIDTH;
  localparam int PTR_WIDTH     = $clog2(DEPTH);
  localparam int CNT_WIDTH     = PTR_WIDTH + 1;

  function automatic logic [ROUTE_WIDTH-1:0] reverse_bits(input logic [ROUTE_WIDTH-1:0] v);
    logic [ROUTE_WIDTH-1:0] r;
    for (int i = 0; i < ROUTE_WIDTH; i++) r[i] = v[ROUTE_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [ROUTE_WIDTH-1:0] ID_BITS = ROUTE_WIDTH'(INPUT_ID);
  localparam logic [ROUTE_WIDTH-1:0] REV_ID  = reverse_bits(ID_BITS);

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_BODY,
    ST_DISCARD
  } state_t;

  state_t state, state_next;
  logic   is_header, discarding;

  logic [FLIT_WIDTH-1:0]  in_flit;
  logic                   in_valid, in_last, in_ready;
  logic [PORTS-1:0]       out_ready, out_valid;

  logic [ROUTE_WIDTH-1:0] hop, cur_port, push_port, head_port;
  logic [FLIT_WIDTH-1:0]  push_flit;
  logic                   bad_header, accept, push, pop;

  logic [FLIT_WIDTH-1:0]  mem_flit [DEPTH];
  logic                   mem_last [DEPTH];
  logic [ROUTE_WIDTH-1:0] mem_port [DEPTH];
  logic [PTR_WIDTH-1:0]   rd_ptr, wr_ptr;
  logic [CNT_WIDTH-1:0]   count;

  assign in_flit   = in_link.flit;
  assign in_valid  = in_link.valid[0];
  assign in_last   = in_link.last;
  assign out_ready = out_link.ready;

  assign in_link.ready  = in_ready;
  assign out_link.flit  = mem_flit[rd_ptr];
  assign out_link.last  = mem_last[rd_ptr];
  assign out_link.valid = out_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HEADER;
    else     state <= state_next;
  end

  // Packet boundaries come only from accepted flits; a bad header diverts the rest of its packet to ST_DISCARD.
  always_comb begin
    state_next = state;
    if (accept) begin
      if (in_last)                 state_next = ST_HEADER;
      else if (state == ST_HEADER) state_next = bad_header ? ST_DISCARD : ST_BODY;
    end
  end

  always_comb begin
    is_header  = (state == ST_HEADER);
    discarding = (state == ST_DISCARD);
  end

  // Discarded flits never touch the FIFO, so they are taken even when it is full.
  always_comb begin
    hop        = in_flit[ROUTE_WIDTH-1:0];
    bad_header = is_header && in_valid && (hop >= ROUTE_WIDTH'(PORTS));
    in_ready   = discarding || bad_header || (count < CNT_WIDTH'(DEPTH));
    accept     = in_valid && in_ready;
    push       = accept && !discarding && !bad_header;
    push_port  = is_header ? hop : cur_port;
    push_flit  = is_header
               ? {in_flit[FLIT_WIDTH-1 -: HEADER_WIDTH], REV_ID, in_flit[ROUTING_WIDTH-1:ROUTE_WIDTH]}
               : in_flit;
  end

  always_comb begin
    head_port = mem_port[rd_ptr];
    out_valid = (count != '0) ? (PORTS'(1) << head_port) : '0;
    pop       = |(out_valid & out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_port <= '0;
    end else if (push && is_header) begin
      cur_port <= hop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_flit[wr_ptr] <= push_flit;
      mem_last[wr_ptr] <= in_last;
      mem_port[wr_ptr] <= push_port;
    end
  end

`ifdef HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (bad_header && drop_count != '1) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hybrid_noc_router_lookup_sr_buf.sv
// Self-checking bench for hybrid_noc_router_lookup_sr_buf: directed scenarios then random packets against a queue model.
module tb_hybrid_noc_router_lookup_sr_buf;

  localparam int FW    = 32;
  localparam int P     = 5;
  localparam int ID    = 2;
  localparam int HW    = 8;
  localparam int D     = 2;
  localparam logic [2:0] REV_ID = 3'b010;

  typedef struct {
    logic [FW-1:0] flit;
    logic          last;
    int            port;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hybrid_noc_router_lookup_sr_buf_if #(.FLIT_WIDTH(FW), .LANES(1)) in_link ();
  hybrid_noc_router_lookup_sr_buf_if #(.FLIT_WIDTH(FW), .LANES(P)) out_link ();

`ifdef HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  hybrid_noc_router_lookup_sr_buf #(
    .FLIT_WIDTH(FW), .PORTS(P), .INPUT_ID(ID), .HEADER_WIDTH(HW), .DEPTH(D), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_link(in_link),
    .out_link(out_link)
`ifdef HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  exp_t q[$];
  bit   m_header   = 1'b1;
  bit   m_dropping = 1'b0;
  int   m_cur      = 0;
  int   m_drops    = 0;
  int   checks     = 0;
  int   errors     = 0;

  task automatic checkOutput(input bit exp_ready);
    logic [P-1:0] exp_valid;
    exp_valid = (q.size() > 0) ? P'(1) << q[0].port : '0;
    checks++;
    assert (in_link.ready[0] === exp_ready) else begin
      errors++;
      $error("[TB] FAIL in_ready: got %b expected %b", in_link.ready[0], exp_ready);
    end
    checks++;
    assert (out_link.valid === exp_valid) else begin
      errors++;
      $error("[TB] FAIL out_valid: got %b expected %b", out_link.valid, exp_valid);
    end
    if (q.size() > 0) begin
      checks++;
      assert (out_link.flit === q[0].flit) else begin
        errors++;
        $error("[TB] FAIL out_flit: got %h expected %h", out_link.flit, q[0].flit);
      end
      checks++;
      assert (out_link.last === q[0].last) else begin
        errors++;
        $error("[TB] FAIL out_last: got %b expected %b", out_link.last, q[0].last);
      end
    end
`ifdef HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN
    checks++;
    assert (drop_count === 16'(m_drops)) else begin
      errors++;
      $error("[TB] FAIL drop_count: got %0d expected %0d", drop_count, m_drops);
    end
`endif
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at the next posedge.
  task automatic applyStimulus(input logic [FW-1:0] f, input bit v, input bit l,
                               input logic [P-1:0] r, output bit acc);
    int  hop;
    bit  bad, exp_ready, popping;
    exp_t e;
    in_link.flit     = f;
    in_link.valid[0] = v;
    in_link.last     = l;
    out_link.ready   = r;
    @(negedge clk);
    hop       = int'(f[2:0]);
    bad       = m_header && v && (hop >= P);
    exp_ready = m_dropping || bad || (q.size() < D);
    checkOutput(exp_ready);
    acc     = v && exp_ready;
    popping = (q.size() > 0) && r[q[0].port];
    @(posedge clk);
    if (popping) void'(q.pop_front());
    if (acc) begin
      if (bad) begin
        m_drops++;
        m_dropping = !l;
      end else if (m_dropping) begin
        if (l) m_dropping = 1'b0;
      end else if (m_header) begin
        e.flit = (f & 32'hFF00_0000) | (32'(REV_ID) << 21) | ((f & 32'h00FF_FFFF) >> 3);
        e.last = l;
        e.port = hop;
        m_cur  = hop;
        q.push_back(e);
      end else begin
        e.flit = f;
        e.last = l;
        e.port = m_cur;
        q.push_back(e);
      end
      m_header = l;
    end
    #1;
  endtask

  task automatic sendFlit(input logic [FW-1:0] f, input bit l, input logic [P-1:0] r);
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) applyStimulus(f, 1'b1, l, r, acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("[TB] FAIL send_timeout: flit %h not accepted, expected acceptance within 40 cycles", f);
    end
  endtask

  task automatic idle(input logic [P-1:0] r, input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0, r, acc);
  endtask

  task automatic applyReset();
    in_link.valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_header   = 1'b1;
    m_dropping = 1'b0;
    m_drops    = 0;
  endtask

  initial begin
    bit            acc, have;
    logic [FW-1:0] f;
    bit            l;
    int            left;
    logic [P-1:0]  r;

    in_link.flit     = '0;
    in_link.valid[0] = 1'b0;
    in_link.last     = 1'b0;
    out_link.ready   = '0;
    repeat (2) @(posedge clk);
    #1;
    applyReset();

    idle('1, 2);

    // 3-flit packet routed to port 3
    sendFlit(32'hA5C3_F00B, 1'b0, '1);
    sendFlit(32'h1111_2222, 1'b0, '1);
    sendFlit(32'h3333_4444, 1'b1, '1);
    idle('1, 3);

    // Bad route 5: whole packet dropped, next one normal
    sendFlit(32'h0000_00FD, 1'b0, '1);
    sendFlit(32'h5555_6666, 1'b0, '1);
    sendFlit(32'h7777_8888, 1'b0, '1);
    sendFlit(32'h9999_AAAA, 1'b1, '1);
    sendFlit(32'hDEAD_BEE9, 1'b1, '1);
    idle('1, 2);

    // Fill with out_ready low, wrong-port ready, then drain on port 2
    sendFlit(32'h1234_567A, 1'b0, '0);
    sendFlit(32'hCAFE_0001, 1'b0, '0);
    applyStimulus(32'hCAFE_0002, 1'b1, 1'b1, '0, acc);
    applyStimulus(32'hCAFE_0002, 1'b1, 1'b1, 5'b00001, acc);
    applyStimulus(32'hCAFE_0002, 1'b1, 1'b1, 5'b11011, acc);
    sendFlit(32'hCAFE_0002, 1'b1, 5'b00100);
    idle(5'b00100, 3);

    // Back-to-back single-flit packets to ports 0, 4, 1
    sendFlit(32'h0BAD_F008, 1'b1, '1);
    sendFlit(32'h0BAD_F00C, 1'b1, '1);
    sendFlit(32'h0BAD_F001, 1'b1, '1);
    idle('1, 3);

    // Reset with two flits buffered mid-packet
    sendFlit(32'h4242_4243, 1'b0, '0);
    sendFlit(32'h4242_0000, 1'b0, '0);
    applyReset();
    idle('0, 1);
    sendFlit(32'h6060_6064, 1'b1, '1);
    idle('1, 2);

    // Random packets, random per-port ready
    have = 1'b0;
    left = 0;
    f    = '0;
    l    = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        if (left == 0) begin
          left = $urandom_range(1, 4);
          f    = {$urandom(), 3'b000} | 32'($urandom_range(0, 7));
        end else begin
          f = $urandom();
        end
        left--;
        l    = (left == 0);
        have = 1'b1;
      end
      r = P'($urandom());
      applyStimulus(f, ($urandom_range(0, 3) != 0), l, r, acc);
      if (acc) have = 1'b0;
    end
    while (have) begin
      applyStimulus(f, 1'b1, l, '1, acc);
      if (acc) have = 1'b0;
    end
    idle('1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hybrid_noc_router_lookup_sr_buf.md
# hybrid_noc_router_lookup_sr_buf

Buffered, parametrised input-port lookup stage for the hybrid NoC router with source routing. It consumes the per-hop route field of each packet header, rewrites the header so the path can be back-traced, and discards packets whose route names a nonexistent port. Flits are stored in a DEPTH-entry FIFO that decouples the input link from output arbitration. It sits between the input link register and the router switch arbiters, one instance per input port.

## Interface
- FLIT_WIDTH, 32, flit width in bits
- PORTS, 5, number of router output ports
- INPUT_ID, 0, index of this input port; its low ROUTE_WIDTH bits are inserted into headers
- HEADER_WIDTH, 8, header MSBs passed through unchanged
- DEPTH, 2, FIFO entries; must be a power of two ≥ 2
- DROP_CNT_WIDTH, 16, drop counter width; used only with the macro
- Derived: ROUTE_WIDTH = $clog2(PORTS+1); ROUTING_WIDTH = FLIT_WIDTH-HEADER_WIDTH
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_flit  in  FLIT_WIDTH  input flit
- in_valid  in  1  input flit valid
- in_last  in  1  input flit is the last flit of its packet
- in_ready  out  1  flit accepted when in_valid & in_ready
- out_flit  out  FLIT_WIDTH  FIFO head flit
- out_valid  out  PORTS  one-hot request for the head flit's output port; all zero when empty
- out_last  out  1  head flit is the last flit of its packet
- out_ready  in  PORTS  per-port grant/ready
- drop_count  out  DROP_CNT_WIDTH  discarded-packet count; present only with the macro

## Operation
- State: is_header (reset 1); discarding (reset 0); cur_port, the route latched at the header; FIFO of {flit, last, port} with rd/wr pointers and a count.
- Header (is_header & in_valid): hop = in_flit[ROUTE_WIDTH-1:0].
  - If hop ≥ PORTS: discard the packet. in_ready = 1 regardless of FIFO fill. Nothing is pushed. Set discarding = ~in_last.
  - Otherwise, when accepted, push {in_flit[FLIT_WIDTH-1 -: HEADER_WIDTH], rev_id, in_flit[ROUTING_WIDTH-1:ROUTE_WIDTH]} with port = hop, and latch cur_port = hop.
  - rev_id is INPUT_ID[ROUTE_WIDTH-1:0] bit-reversed.
- Body/tail flits: pushed unmodified with port = cur_port. While discarding, they are accepted (in_ready = 1) and dropped.
- is_header is set after an accepted or discarded flit with in_last. It is cleared after an accepted or discarded non-last header. A single-flit packet leaves is_header = 1.
- in_ready = (discarding | header-discard condition) | (count < DEPTH). There is no pop-to-push bypass, so a full FIFO stalls input even in a pop cycle.
- Output: out_valid = count≠0 ? (1 << head.port) : 0. A pop occurs when |(out_valid & out_ready). Ready bits on other ports are ignored.
- A simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Latency: a flit accepted at edge N is visible on out_* after edge N, i.e. 1 cycle. There is no combinational in→out path.
- Throughput: 1 flit/cycle sustained when out_ready is continuously high.
- Reset values: out_valid = 0, in_ready = 1, drop_count = 0. out_flit and out_last are don't-care while out_valid = 0.
- Reset mid-packet: the FIFO is flushed, is_header = 1, discarding = 0. The upstream link must reset at the same time.
- out_valid and out_flit must stay stable while unpopped.

## Configuration
- HYBRID_NOC_LOOKUP_SR_DROP_CNT_EN defined: drop_count port exists. It is a saturating counter that increments by 1 on each discarded header flit and holds at 2^DROP_CNT_WIDTH-1.
- Macro undefined: the port and the counter are absent. Discard behaviour is otherwise identical.

## Test plan
- PORTS=5, INPUT_ID=2 (ROUTE_WIDTH=3, rev_id=3'b010); 3-flit packet, header route field 3'b011, out_ready all 1 → out_valid=5'b01000 from the cycle after each accept; header rewritten with 3'b010 inserted and routing shifted right by 3; body flits unchanged; out_last on flit 3.
- Header route 3'b101 (≥ PORTS), 4-flit packet → in_ready stays 1; no out_valid; next packet routed normally; drop_count=1 with the macro.
- DEPTH=2, out_ready=0 → two flits accepted, then in_ready=0; asserting out_ready[hop] pops one flit per cycle in order.
- out_ready asserted only on a port other than the head's → no pop; the head is held stable.
- Back-to-back single-flit packets to ports 0, 4, 1 → 1 flit/cycle; out_valid sequence 00001, 10000, 00010.
- Assert rst with 2 flits buffered and mid-packet → out_valid=0 the next cycle; the next flit is treated as a header.
